// File: rtl/topk_pkg.sv
// Shared types and constants for the top-K group tracker.
package topk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } state_e;

  // Bit positions inside the sticky err vector.
  localparam int ERR_W      = 3;
  localparam int ERR_OVF    = 0;
  localparam int ERR_RDBUSY = 1;
  localparam int ERR_STALL  = 2;

  // Stall watchdog fires after 2^STALL_W consecutive refused beats.
  localparam int STALL_W = 16;

endpackage

// File: rtl/topk_sorted_insert.sv
// Descending sorted table of the TOP_K largest values seen.
// One insert per cycle; ties keep the resident entry ahead of the newcomer.
// tbl_o is the table as it stands after this cycle's insert (next-state
// view), so a snapshot taken on the same edge already includes it.
module topk_sorted_insert
  import topk_pkg::*;
#(
  parameter int SUM_W = 40,
  parameter int TOP_K = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ins_vld_i,
  input  logic [SUM_W-1:0]              ins_val_i,
  output logic [TOP_K-1:0][SUM_W-1:0]   tbl_o
);

  logic [TOP_K-1:0][SUM_W-1:0] tbl_q, tbl_d;
  logic [TOP_K-1:0]            ge;

  // The table is sorted, so ge is a thermometer code: ones for ranks < p.
  // Rank p takes the new value, ranks above p take their upper neighbour.
  for (genvar i = 0; i < TOP_K; i++) begin : g_ent
    assign ge[i] = (tbl_q[i] >= ins_val_i);
    if (i == 0) begin : g_head
      assign tbl_d[i] = (!ins_vld_i || ge[i]) ? tbl_q[i] : ins_val_i;
    end else begin : g_tail
      assign tbl_d[i] = (!ins_vld_i || ge[i]) ? tbl_q[i]  :
                        ge[i-1]               ? ins_val_i : tbl_q[i-1];
    end
  end

  assign tbl_o = tbl_d;

  // Table register.
  always_ff @(posedge clk) begin
    if (!rst_n) tbl_q <= '0;
    else        tbl_q <= tbl_d;
  end

endmodule

// File: rtl/topk_group_tracker.sv
// Group-sum accumulator feeding a top-K sorted table, with a valid/ready
// rank-by-rank readout of a snapshot and its total.
// Optional macro TOPK_SATURATE_EN: clamp the running sum at 2^SUM_W-1 on
// overflow instead of wrapping (err[0] is raised either way).
module topk_group_tracker
  import topk_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int SUM_W  = 40,
  parameter  int TOP_K  = 3,
  localparam int RANK_W = (TOP_K > 1) ? $clog2(TOP_K) : 1,
  localparam int TOT_W  = SUM_W + $clog2(TOP_K + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] item_data,
  input  logic              item_vld,
  input  logic              grp_end,
  input  logic              rd_req,
  output logic [SUM_W-1:0]  out_data,
  output logic [RANK_W-1:0] out_rank,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              out_last,
  output logic [TOT_W-1:0]  total_sum,
  output logic              busy,
  output logic [ERR_W-1:0]  err
);

  localparam logic [RANK_W-1:0] LAST_IDX = RANK_W'(TOP_K - 1);

  // ---------------- accumulate / commit ----------------
  logic [SUM_W-1:0] acc_q, commit_q;
  logic             commit_vld_q;
  logic [SUM_W-1:0] item_add, acc_add;
  logic [SUM_W:0]   acc_sum;
  logic             ovf;

  assign item_add = item_vld ? SUM_W'(item_data) : '0;
  assign acc_sum  = {1'b0, acc_q} + {1'b0, item_add};
  assign ovf      = acc_sum[SUM_W];

`ifdef TOPK_SATURATE_EN
  // Once clamped, any further nonzero item carries again, so it stays clamped.
  assign acc_add = ovf ? '1 : acc_sum[SUM_W-1:0];
`else
  assign acc_add = acc_sum[SUM_W-1:0];
`endif

  // Running sum; on grp_end the current item joins the closing group.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q        <= '0;
      commit_q     <= '0;
      commit_vld_q <= 1'b0;
    end else begin
      commit_vld_q <= grp_end;
      if (grp_end) begin
        commit_q <= acc_add;
        acc_q    <= '0;
      end else begin
        acc_q <= acc_add;
      end
    end
  end

  // ---------------- sorted table ----------------
  logic [TOP_K-1:0][SUM_W-1:0] tbl_nxt, snap_q;
  logic [TOT_W-1:0]            tot_nxt, total_q;

  topk_sorted_insert #(.SUM_W(SUM_W), .TOP_K(TOP_K)) u_tbl (
    .clk       (clk),
    .rst_n     (rst_n),
    .ins_vld_i (commit_vld_q),
    .ins_val_i (commit_q),
    .tbl_o     (tbl_nxt)
  );

  // Total of the table as it will be latched into the snapshot.
  always_comb begin
    tot_nxt = '0;
    for (int i = 0; i < TOP_K; i++) tot_nxt = tot_nxt + TOT_W'(tbl_nxt[i]);
  end

  // ---------------- readout FSM ----------------
  state_e            state_q, state_d;
  logic [RANK_W-1:0] idx_q, idx_d;
  logic              snap_ld;

  // Next state and beat outputs; beat fields come only from registers so they
  // hold still while the consumer stalls.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    snap_ld  = 1'b0;
    out_vld  = 1'b0;
    out_last = 1'b0;
    out_data = '0;
    out_rank = '0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          snap_ld = 1'b1;
          idx_d   = '0;
          state_d = DUMP;
        end
      end
      DUMP: begin
        out_vld  = 1'b1;
        busy     = 1'b1;
        out_data = snap_q[idx_q];
        out_rank = idx_q;
        out_last = (idx_q == LAST_IDX);
        if (out_rdy) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, beat index and snapshot/total capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (snap_ld) begin
        snap_q  <= tbl_nxt;
        total_q <= tot_nxt;
      end
    end
  end

  assign total_sum = total_q;

  // ---------------- error flags ----------------
  logic [STALL_W-1:0] stall_q;
  logic [ERR_W-1:0]   err_q;
  logic               stall;

  assign stall = out_vld && !out_rdy;

  // Sticky errors plus a saturating count of consecutive refused beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      err_q   <= '0;
    end else begin
      if (!stall)              stall_q <= '0;
      else if (stall_q != '1)  stall_q <= stall_q + 1'b1;
      if (ovf)                          err_q[ERR_OVF]    <= 1'b1;
      if (rd_req && state_q == DUMP)    err_q[ERR_RDBUSY] <= 1'b1;
      if (stall && stall_q == '1)       err_q[ERR_STALL]  <= 1'b1;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_topk_group_tracker.sv
`timescale 1ns/1ps
module tb_topk_group_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] item_data = '0;
  logic        item_vld = 1'b0, grp_end = 1'b0, rd_req = 1'b0, out_rdy = 1'b0;

  always #5 clk = ~clk;

  // main instance: DATA_W=32 SUM_W=40 TOP_K=3
  logic [39:0] m_data; logic [1:0] m_rank; logic m_vld, m_last, m_busy;
  logic [41:0] m_tot;  logic [2:0] m_err;
  // narrow instance: DATA_W=SUM_W=8 TOP_K=3
  logic [7:0]  n_data; logic [1:0] n_rank; logic n_vld, n_last, n_busy;
  logic [9:0]  n_tot;  logic [2:0] n_err;
  // single-entry instance: TOP_K=1
  logic [39:0] k_data; logic [0:0] k_rank; logic k_vld, k_last, k_busy;
  logic [40:0] k_tot;  logic [2:0] k_err;

  topk_group_tracker #(.DATA_W(32), .SUM_W(40), .TOP_K(3)) u_main (
    .clk(clk), .rst_n(rst_n), .item_data(item_data), .item_vld(item_vld),
    .grp_end(grp_end), .rd_req(rd_req), .out_data(m_data), .out_rank(m_rank),
    .out_vld(m_vld), .out_rdy(out_rdy), .out_last(m_last), .total_sum(m_tot),
    .busy(m_busy), .err(m_err));

  topk_group_tracker #(.DATA_W(8), .SUM_W(8), .TOP_K(3)) u_narrow (
    .clk(clk), .rst_n(rst_n), .item_data(item_data[7:0]), .item_vld(item_vld),
    .grp_end(grp_end), .rd_req(rd_req), .out_data(n_data), .out_rank(n_rank),
    .out_vld(n_vld), .out_rdy(out_rdy), .out_last(n_last), .total_sum(n_tot),
    .busy(n_busy), .err(n_err));

  topk_group_tracker #(.DATA_W(32), .SUM_W(40), .TOP_K(1)) u_k1 (
    .clk(clk), .rst_n(rst_n), .item_data(item_data), .item_vld(item_vld),
    .grp_end(grp_end), .rd_req(rd_req), .out_data(k_data), .out_rank(k_rank),
    .out_vld(k_vld), .out_rdy(out_rdy), .out_last(k_last), .total_sum(k_tot),
    .busy(k_busy), .err(k_err));

  // Observed instance selector.
  int sel = 0;
  logic [39:0] s_data; logic [1:0] s_rank; logic s_vld, s_last, s_busy;
  logic [41:0] s_tot;  logic [2:0] s_err;
  always_comb begin
    s_data = m_data; s_rank = m_rank; s_vld = m_vld; s_last = m_last;
    s_busy = m_busy; s_tot = m_tot;   s_err = m_err;
    case (sel)
      1: begin
        s_data = {32'b0, n_data}; s_rank = n_rank; s_vld = n_vld; s_last = n_last;
        s_busy = n_busy; s_tot = {32'b0, n_tot}; s_err = n_err;
      end
      2: begin
        s_data = k_data; s_rank = {1'b0, k_rank}; s_vld = k_vld; s_last = k_last;
        s_busy = k_busy; s_tot = {1'b0, k_tot}; s_err = k_err;
      end
      default: ;
    endcase
  end

  typedef struct { logic [1:0] rank; logic [39:0] data; logic last; } beat_t;
  beat_t       exp_q[$];
  int          errs = 0, checks = 0;
  logic [39:0] mdl [3];
  logic [39:0] acc_m;

  // Reference top-3 table for the main instance.
  task automatic mdl_insert(input logic [39:0] v);
    int p = 0;
    for (int i = 0; i < 3; i++) if (mdl[i] >= v) p++;
    if (p < 3) begin
      for (int i = 2; i > p; i--) mdl[i] = mdl[i-1];
      mdl[p] = v;
    end
  endtask

  function automatic logic [41:0] mdl_total();
    logic [41:0] t = '0;
    for (int i = 0; i < 3; i++) t += {2'b0, mdl[i]};
    return t;
  endfunction

  task automatic push_mdl();
    beat_t b;
    for (int i = 0; i < 3; i++) begin
      b.rank = 2'(i); b.data = mdl[i]; b.last = (i == 2);
      exp_q.push_back(b);
    end
  endtask

  task automatic push_beat(input logic [1:0] r, input logic [39:0] d, input logic l);
    beat_t b;
    b.rank = r; b.data = d; b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; item_vld = 0; grp_end = 0; rd_req = 0; item_data = '0; out_rdy = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) mdl[i] = '0;
    acc_m = '0;
    exp_q.delete();
  endtask

  task automatic send_item(input logic [31:0] v, input logic last);
    item_data = v; item_vld = 1'b1; grp_end = last;
    acc_m = acc_m + {8'b0, v};
    @(negedge clk);
    item_vld = 1'b0; grp_end = 1'b0; item_data = '0;
    if (last) begin mdl_insert(acc_m); acc_m = '0; end
  endtask

  task automatic send_std_groups();
    send_item(1000, 0); send_item(2000, 0); send_item(3000, 1);
    send_item(4000, 1);
    send_item(5000, 0); send_item(6000, 1);
    send_item(7000, 0); send_item(8000, 0); send_item(9000, 1);
    send_item(10000, 1);
  endtask

  // Request a dump, drain expected beats under a 4-cycle ready pattern.
  task automatic run_dump(input logic [3:0] pat, input bit mid_rd,
                          input logic [41:0] etot, input string nm);
    int cyc = 0; bit stl = 0; beat_t b;
    logic [39:0] hd = '0; logic [1:0] hr = '0; logic hl = 1'b0;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    checks++;
    if (s_vld !== 1'b1 || s_busy !== 1'b1) begin
      errs++; $display("FAIL %s_enter: vld=%b busy=%b want 1 1", nm, s_vld, s_busy);
    end
    checks++;
    if (s_tot !== etot) begin
      errs++; $display("FAIL %s_total: got %0d want %0d", nm, s_tot, etot);
    end
    while (exp_q.size() > 0 && cyc < 64) begin
      out_rdy = pat[cyc % 4];
      rd_req  = mid_rd && (cyc == 1);
      if (stl) begin
        checks++;
        if (s_data !== hd || s_rank !== hr || s_last !== hl) begin
          errs++;
          $display("FAIL %s_hold: got r%0d d%0d l%b want r%0d d%0d l%b",
                   nm, s_rank, s_data, s_last, hr, hd, hl);
        end
      end
      if (s_vld && out_rdy) begin
        b = exp_q.pop_front();
        checks++;
        if (s_data !== b.data || s_rank !== b.rank || s_last !== b.last) begin
          errs++;
          $display("FAIL %s_beat: got r%0d d%0d l%b want r%0d d%0d l%b",
                   nm, s_rank, s_data, s_last, b.rank, b.data, b.last);
        end
      end
      stl = s_vld && !out_rdy; hd = s_data; hr = s_rank; hl = s_last;
      @(negedge clk);
      cyc++;
    end
    out_rdy = 1'b0; rd_req = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errs++; $display("FAIL %s_timeout: %0d beats missing want 0", nm, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (s_vld !== 1'b0 || s_busy !== 1'b0) begin
      errs++; $display("FAIL %s_exit: vld=%b busy=%b want 0 0", nm, s_vld, s_busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({m_vld, m_last, m_busy} !== 3'b0 || m_data !== '0 || m_rank !== '0 ||
        m_tot !== '0 || m_err !== '0) begin
      errs++;
      $display("FAIL reset_main: vld%b last%b busy%b d%0d r%0d tot%0d err%b want all 0",
               m_vld, m_last, m_busy, m_data, m_rank, m_tot, m_err);
    end
    checks++;
    if ({n_vld, k_vld, n_busy, k_busy} !== 4'b0 || n_err !== '0 || k_err !== '0) begin
      errs++; $display("FAIL reset_others: n_vld%b k_vld%b n_err%b k_err%b want 0",
                       n_vld, k_vld, n_err, k_err);
    end
  endtask

  task automatic test_basic();
    do_reset(); sel = 0;
    send_std_groups();
    push_mdl();
    checks++;
    if (mdl_total() !== 42'd45000) begin
      errs++; $display("FAIL basic_model_total: got %0d want 45000", mdl_total());
    end
    run_dump(4'b1111, 1'b0, mdl_total(), "basic");
    checks++;
    if (m_err !== 3'b000) begin errs++; $display("FAIL basic_err: got %b want 000", m_err); end
  endtask

  task automatic test_stall();
    do_reset(); sel = 0;
    send_std_groups();
    push_mdl();
    run_dump(4'b1001, 1'b1, mdl_total(), "stall");
    checks++;
    if (m_err !== 3'b010) begin errs++; $display("FAIL stall_rdbusy: got %b want 010", m_err); end
  endtask

  task automatic test_back_to_back();
    do_reset(); sel = 0;
    send_item(500, 1); send_item(500, 1); send_item(700, 1); send_item(500, 1);
    push_beat(2'd0, 40'd700, 1'b0); push_beat(2'd1, 40'd500, 1'b0); push_beat(2'd2, 40'd500, 1'b1);
    run_dump(4'b1111, 1'b0, 42'd1700, "b2b");
  endtask

  task automatic test_overflow();
    logic [39:0] w;
`ifdef TOPK_SATURATE_EN
    w = 40'd255;
`else
    w = 40'd44;
`endif
    do_reset(); sel = 1;
    send_item(200, 0); send_item(100, 0);
    grp_end = 1'b1; @(negedge clk); grp_end = 1'b0;
    push_beat(2'd0, w, 1'b0); push_beat(2'd1, 40'd0, 1'b0); push_beat(2'd2, 40'd0, 1'b1);
    run_dump(4'b1111, 1'b0, {2'b0, w}, "ovf");
    checks++;
    if (n_err !== 3'b001) begin errs++; $display("FAIL ovf_err_narrow: got %b want 001", n_err); end
    checks++;
    if (m_err !== 3'b000) begin errs++; $display("FAIL ovf_err_wide: got %b want 000", m_err); end
  endtask

  task automatic test_reset_mid_dump();
    do_reset(); sel = 0;
    send_std_groups();
    rd_req = 1'b1; @(negedge clk); rd_req = 1'b0;
    out_rdy = 1'b1; @(negedge clk); out_rdy = 1'b0;
    checks++;
    if (m_vld !== 1'b1 || m_rank !== 2'd1) begin
      errs++; $display("FAIL rstdump_beat1: vld%b rank%0d want 1 1", m_vld, m_rank);
    end
    rst_n = 1'b0; @(negedge clk);
    checks++;
    if (m_vld !== 1'b0 || m_busy !== 1'b0 || m_tot !== '0 || m_err !== '0) begin
      errs++; $display("FAIL rstdump_abort: vld%b busy%b tot%0d err%b want 0",
                       m_vld, m_busy, m_tot, m_err);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) mdl[i] = '0;
    push_mdl();
    run_dump(4'b1111, 1'b0, 42'd0, "rstdump_zero");
  endtask

  task automatic test_topk1();
    do_reset(); sel = 2;
    send_item(5, 1); send_item(9, 1); send_item(3, 1);
    push_beat(2'd0, 40'd9, 1'b1);
    run_dump(4'b1111, 1'b0, 42'd9, "k1");
  endtask

  task automatic test_stall_watchdog();
    do_reset(); sel = 0;
    rd_req = 1'b1; @(negedge clk); rd_req = 1'b0;
    repeat (65535) @(negedge clk);
    checks++;
    if (m_err[2] !== 1'b0) begin errs++; $display("FAIL wdog_early: got %b want 0", m_err[2]); end
    @(negedge clk);
    checks++;
    if (m_err[2] !== 1'b1 || m_vld !== 1'b1) begin
      errs++; $display("FAIL wdog_fire: err2=%b vld=%b want 1 1", m_err[2], m_vld);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_reset_mid_dump();
    test_topk1();
    test_stall_watchdog();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
